// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg
// Shared types and constants for the instruction fetch controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

   // Fetch controller state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Value shown on instr_o/pc_o while the buffer is empty
   localparam logic [31:0] NOP_INSTR = 32'b0;

   // Byte increment between consecutive instruction words
   localparam logic [31:0] PC_STEP = 32'd4;

   // One prefetch buffer entry: byte address plus the word fetched from it
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo
// DEPTH-entry synchronous FIFO of fetch entries with flush, simultaneous
// push/pop (also when full) and an occupancy count.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  fetch_entry_t               wdata,
   output fetch_entry_t               rdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           pop_ok;
   logic           push_ok;

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push
   assign pop_ok  = pop & (count != '0) & ~flush;
   assign push_ok = push & ((count != FULL_CNT) | pop_ok) & ~flush;

   assign rdata = mem[rd_ptr];

   // Storage array: written on accepted push; contents need no reset
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and count; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
// instr_fetch_ctrl
// Fetch controller: owns the fetch PC, reads instruction memory, buffers
// fetched words and hands them to decode over valid/ready. Handles
// redirects and halts when the PC leaves the legal memory range.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 32,
   parameter int          DEPTH     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic        fault_o
);

   localparam int          CW        = $clog2(DEPTH) + 1;
   localparam logic [31:0] LAST_ADDR = 32'((MEM_WORDS - 1) * 4);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  new_entry;
   logic          in_range;
   logic          valid;
   logic          pop;
   logic          push;

   // Plain unsigned compare: no wrap back into word 0 past the top of memory
   assign in_range  = (fetch_pc <= LAST_ADDR);
   assign valid     = (count != '0);
   assign pop       = valid & instr_ready_i;
   assign push      = (state == RUN) & en_i & in_range & ~redirect_i &
                      ((count != FULL_CNT) | pop);
   assign new_entry = '{pc: fetch_pc, instr: imem_instr_i};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .flush (redirect_i),
      .push  (push),
      .pop   (pop),
      .wdata (new_entry),
      .rdata (head),
      .count (count)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; redirect overrides everything, including HALT
   always_comb begin
      state_nxt = state;
      if (redirect_i) begin
         state_nxt = en_i ? RUN : IDLE;
      end else begin
         case (state)
            IDLE: if (en_i) state_nxt = RUN;
            RUN: begin
               if (!en_i) begin
                  state_nxt = IDLE;
               end else if (!in_range) begin
                  state_nxt = HALT;
               end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Fetch PC: redirect target is word-aligned, otherwise step on each push
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i & ~32'h3;
      end else if (push) begin
         fetch_pc <= fetch_pc + PC_STEP;
      end
   end

   // Outputs are driven from registered state only
   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = valid;
   assign instr_o       = valid ? head.instr : NOP_INSTR;
   assign pc_o          = valid ? head.pc : 32'b0;
   assign fault_o       = (state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
// tb_instr_fetch_ctrl
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized phase compared against a queue-based reference model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

   localparam logic [31:0] LAST = 32'd124;   // (32-1)*4

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'b0;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic        fault_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory contents: word n holds n+1
   assign imem_instr_i = (imem_addr_o >> 2) + 32'd1;

   instr_fetch_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .MEM_WORDS (32),
      .DEPTH     (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_instr_i  (imem_instr_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .fault_o       (fault_o)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   int          m_mode;   // 0 = idle, 1 = running, 2 = halted

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'h0;
      m_mode = 0;
   endtask

   task automatic model_compare();
      logic        v;
      logic [31:0] ei;
      logic [31:0] ep;
      v  = (mq.size() != 0);
      ei = v ? mq[0].instr : 32'h0;
      ep = v ? mq[0].pc : 32'h0;
      chk("m_valid", 32'(instr_valid_o), 32'(v));
      chk("m_instr", instr_o, ei);
      chk("m_pc", pc_o, ep);
      chk("m_addr", imem_addr_o, m_pc);
      chk("m_fault", 32'(fault_o), 32'(m_mode == 2));
   endtask

   task automatic model_edge(input bit en, input bit redir, input logic [31:0] rpc, input bit rdy);
      bit pop;
      bit push;
      bit inr;
      pop = (mq.size() != 0) && rdy;
      inr = (m_pc <= LAST);
      if (redir) begin
         mq.delete();
         m_pc   = rpc & ~32'h3;
         m_mode = en ? 1 : 0;
      end else begin
         push = (m_mode == 1) && en && inr && (mq.size() < 2 || pop);
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back('{m_pc, (m_pc >> 2) + 32'd1});
            m_pc = m_pc + 32'd4;
         end
         if (m_mode == 0 && en) m_mode = 1;
         else if (m_mode == 1 && !en) m_mode = 0;
         else if (m_mode == 1 && !inr) m_mode = 2;
      end
   endtask

   // Drive one cycle of inputs, check the model, then cross one rising edge
   task automatic cycle(input bit en, input bit redir, input logic [31:0] rpc, input bit rdy);
      en_i          = en;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      instr_ready_i = rdy;
      #1;
      model_compare();
      model_edge(en, redir, rpc, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input bit v, input logic [31:0] p,
                             input logic [31:0] ins, input logic [31:0] a, input bit f);
      chk({tag, "_valid"}, 32'(instr_valid_o), 32'(v));
      chk({tag, "_pc"}, pc_o, p);
      chk({tag, "_instr"}, instr_o, ins);
      chk({tag, "_addr"}, imem_addr_o, a);
      chk({tag, "_fault"}, 32'(fault_o), 32'(f));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          en;
      bit          redir;
      logic [31:0] rpc;
      bit          rdy;
      bit          valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[18];

   initial begin
      // inputs for the cycle, then outputs expected after its edge
      tbl[0]  = '{1, 0, 32'h0,  1, 0, 32'h00, 32'd0, 32'h00};
      tbl[1]  = '{1, 0, 32'h0,  1, 1, 32'h00, 32'd1, 32'h04};
      tbl[2]  = '{1, 0, 32'h0,  0, 1, 32'h00, 32'd1, 32'h08};
      tbl[3]  = '{1, 0, 32'h0,  0, 1, 32'h00, 32'd1, 32'h08};
      tbl[4]  = '{1, 0, 32'h0,  0, 1, 32'h00, 32'd1, 32'h08};
      tbl[5]  = '{1, 0, 32'h0,  0, 1, 32'h00, 32'd1, 32'h08};
      tbl[6]  = '{1, 0, 32'h0,  0, 1, 32'h00, 32'd1, 32'h08};
      tbl[7]  = '{1, 0, 32'h0,  1, 1, 32'h04, 32'd2, 32'h0C};
      tbl[8]  = '{1, 0, 32'h0,  1, 1, 32'h08, 32'd3, 32'h10};
      tbl[9]  = '{1, 0, 32'h0,  0, 1, 32'h08, 32'd3, 32'h10};
      tbl[10] = '{1, 1, 32'h13, 0, 0, 32'h00, 32'd0, 32'h10};
      tbl[11] = '{1, 0, 32'h0,  1, 1, 32'h10, 32'd5, 32'h14};
      tbl[12] = '{1, 0, 32'h0,  0, 1, 32'h10, 32'd5, 32'h18};
      tbl[13] = '{0, 0, 32'h0,  1, 1, 32'h14, 32'd6, 32'h18};
      tbl[14] = '{0, 0, 32'h0,  1, 0, 32'h00, 32'd0, 32'h18};
      tbl[15] = '{0, 0, 32'h0,  1, 0, 32'h00, 32'd0, 32'h18};
      tbl[16] = '{1, 0, 32'h0,  1, 0, 32'h00, 32'd0, 32'h18};
      tbl[17] = '{1, 0, 32'h0,  1, 1, 32'h18, 32'd7, 32'h1C};

      // Reset: force a clean falling edge on the asynchronous reset
      #1 rst_i = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      expect_out("reset", 0, 32'h0, 32'h0, 32'h0, 0);
      rst_i = 1'b1;

      // Table-driven directed sequence
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].en, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
         expect_out($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].pc, tbl[i].instr, tbl[i].addr, 0);
      end

      // Run off the end of memory: last word 124 is delivered, then halt
      cycle(1, 1, 32'h74, 1);
      expect_out("end0", 0, 32'h0, 32'h0, 32'h74, 0);
      cycle(1, 0, 32'h0, 1);
      expect_out("end1", 1, 32'h74, 32'd30, 32'h78, 0);
      cycle(1, 0, 32'h0, 1);
      expect_out("end2", 1, 32'h78, 32'd31, 32'h7C, 0);
      cycle(1, 0, 32'h0, 1);
      expect_out("end3", 1, 32'h7C, 32'd32, 32'h80, 0);
      cycle(1, 0, 32'h0, 1);
      expect_out("halt0", 0, 32'h0, 32'h0, 32'h80, 1);
      cycle(1, 0, 32'h0, 1);
      expect_out("halt1", 0, 32'h0, 32'h0, 32'h80, 1);
      cycle(1, 1, 32'h0, 1);
      expect_out("resume0", 0, 32'h0, 32'h0, 32'h0, 0);
      cycle(1, 0, 32'h0, 1);
      expect_out("resume1", 1, 32'h0, 32'd1, 32'h4, 0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom_range(0, 160);
         cycle(($urandom % 8) != 0, ($urandom % 16) == 0, r, ($urandom % 3) != 0);
      end

      // Mid-stream asynchronous reset with a filled buffer
      cycle(1, 1, 32'h40, 1);
      cycle(1, 0, 32'h0, 0);
      cycle(1, 0, 32'h0, 0);
      expect_out("prerst", 1, 32'h40, 32'd17, 32'h48, 0);
      #2 rst_i = 1'b0;
      #1;
      model_reset();
      expect_out("midrst", 0, 32'h0, 32'h0, 32'h0, 0);
      @(posedge clk);
      #1 rst_i = 1'b1;
      cycle(1, 0, 32'h0, 1);
      cycle(1, 0, 32'h0, 1);
      expect_out("restart", 1, 32'h0, 32'd1, 32'h4, 0);
      cycle(1, 0, 32'h0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
